seg7_count_monitor: RTL

- Receive-side checker for the Counter8 output interface: binary count `oQ[2:0]` and seven-segment pattern `oDisplay[6:0]`.
- Decodes each sampled segment pattern back to a value and checks it against the accompanying binary count.
- Tracks the expected mod-8 up-count sequence and flags and counts errors.
- Sits downstream of the counter, in the bench or on-board self-test.

---
 rtl/seg7_count_monitor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/seg7_count_monitor.sv
// Checks a counter's binary value against its seven-segment glyph and tracks the mod-8 up-count.
// All outputs are registered; a sample with iValid=1 is reflected one cycle later.
module seg7_count_monitor #(
    parameter int LOCK_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             iValid,
    input  logic [2:0]       iQ,
    input  logic [6:0]       iDisplay,
    output logic [2:0]       oValue,
    output logic             oLocked,
    output logic             oSeqErr,
    output logic             oMismatch,
    output logic             oBadPattern,
    output logic [ERR_W-1:0] oErrCount
);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        LOCKING = 2'd1,
        TRACK   = 2'd2
    } state_t;

    localparam logic [2:0]       LOCK_CNT = 3'(LOCK_COUNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state_q;
    logic [2:0]       last_q;
    logic [2:0]       run_q;
    logic [2:0]       value_q;
    logic             locked_q;
    logic             seq_err_q;
    logic             mismatch_q;
    logic             bad_q;
    logic [ERR_W-1:0] err_cnt_q;

    logic             dec_ok;
    logic [2:0]       dec_val;
    logic             good;
    logic             insequence;
    logic [2:0]       run_d;
    logic [ERR_W-1:0] err_cnt_d;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 3'd0;
        case (iDisplay)
            7'b1000000: dec_val = 3'd0;
            7'b1111001: dec_val = 3'd1;
            7'b0100100: dec_val = 3'd2;
            7'b0110000: dec_val = 3'd3;
            7'b0011001: dec_val = 3'd4;
            7'b0010010: dec_val = 3'd5;
            7'b0000010: dec_val = 3'd6;
            7'b1111000: dec_val = 3'd7;
            default:    dec_ok  = 1'b0;
        endcase
    end

    always_comb begin
        good       = dec_ok && (dec_val == iQ);
        insequence = good && (dec_val == last_q + 3'd1);
        run_d      = run_q + 3'd1;
        err_cnt_d  = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= SYNC;
            last_q     <= 3'd0;
            run_q      <= 3'd0;
            value_q    <= 3'd0;
            locked_q   <= 1'b0;
            seq_err_q  <= 1'b0;
            mismatch_q <= 1'b0;
            bad_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            seq_err_q  <= 1'b0;
            mismatch_q <= 1'b0;
            bad_q      <= 1'b0;
            if (iValid) begin
                bad_q      <= !dec_ok;
                mismatch_q <= dec_ok && (dec_val != iQ);
                if (good) begin
                    last_q  <= dec_val;
                    value_q <= dec_val;
                end
                case (state_q)
                    SYNC: begin
                        if (good) begin
                            run_q <= 3'd1;
                            if (LOCK_COUNT == 1) begin
                                state_q  <= TRACK;
                                locked_q <= 1'b1;
                            end else begin
                                state_q <= LOCKING;
                            end
                        end
                    end
                    LOCKING: begin
                        if (insequence) begin
                            run_q <= run_d;
                            if (run_d == LOCK_CNT) begin
                                state_q  <= TRACK;
                                locked_q <= 1'b1;
                            end
                        end else if (good) begin
                            run_q <= 3'd1;
                        end else begin
                            state_q <= SYNC;
                            run_q   <= 3'd0;
                        end
                    end
                    TRACK: begin
                        // A good-but-out-of-order sample still updates last_q above
                        if (!insequence) begin
                            seq_err_q <= 1'b1;
                            err_cnt_q <= err_cnt_d;
                            state_q   <= SYNC;
                            locked_q  <= 1'b0;
                            run_q     <= 3'd0;
                        end
                    end
                    default: begin
                        state_q  <= SYNC;
                        locked_q <= 1'b0;
                        run_q    <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign oValue      = value_q;
    assign oLocked     = locked_q;
    assign oSeqErr     = seq_err_q;
    assign oMismatch   = mismatch_q;
    assign oBadPattern = bad_q;
    assign oErrCount   = err_cnt_q;

endmodule
